// File: rtl/pl_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RISC-V pipeline, with a data-memory wait FSM and timeout.
// Optional performance counters are built when HAZ_PERF_EN is defined.
module pl_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic [1:0] ResultSrcE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       MemAccM,
    input  logic       dmem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_err
`ifdef HAZ_PERF_EN
   ,output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic               init_q;
    logic               lu;
    logic               freeze;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lu = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));

    // Freeze also covers the RUN cycle in which the wait is first detected
    assign freeze = !init_q &&
                    (((state_q == RUN)      && MemAccM && !dmem_ready) ||
                     ((state_q == MEM_WAIT) && !dmem_ready) ||
                      (state_q == ERR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            init_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            init_q     <= 1'b0;
        end
    end

    // The scrub cycle clears the pipeline, so no wait is started from it
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        if (!init_q) begin
            case (state_q)
                RUN: begin
                    if (MemAccM && !dmem_ready) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == TO_CNT) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                ERR: begin
                    mem_err_d = 1'b1;
                end
                default: begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst_n) begin
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
            if (init_q) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushW = 1'b1;
            end else if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lu;
                StallD = lu;
                FlushE = lu | PCSrcE;
                FlushD = PCSrcE;
            end
        end
    end

    assign mem_err = mem_err_q;

`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (StallF)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (FlushD && !init_q)
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed scoreboard bench for pl_hazard_ctrl (default build, small timeout).
module tb_pl_hazard_ctrl;

    localparam int TO = 4;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,mem_err}
    localparam logic [11:0] ZERO   = 12'b0000_000_00_00_0;
    localparam logic [11:0] SCRUB  = 12'b0000_111_00_00_0;
    localparam logic [11:0] FREEZE = 12'b1111_001_00_00_0;
    localparam logic [11:0] FRZERR = 12'b1111_001_00_00_1;
    localparam logic [11:0] LUSE   = 12'b1100_010_00_00_0;
    localparam logic [11:0] BRANCH = 12'b0000_110_00_00_0;
    localparam logic [11:0] LU_BR  = 12'b1100_110_00_00_0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, MemAccM, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [1:0] ForwardAE, ForwardBE;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pl_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemAccM(MemAccM), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemAccM = 0; dmem_ready = 1;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Expected value is queued when the stimulus is applied, checked once outputs settle
    task automatic step(input string tag, input logic [11:0] ev);
        exp_t e;
        logic [11:0] obs;
        e.tag = tag;
        e.v   = ev;
        sb.push_back(e);
        #2;
        obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, mem_err};
        e = sb.pop_front();
        n_tests++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", e.tag, obs, e.v);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        RegWriteM = 1; RdM = 5; Rs1E = 5; ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            step("reset_hold", ZERO);
        end

        nxt(); idle(); rst_n = 1'b1;
        step("scrub", SCRUB);
        nxt();
        step("idle_after_scrub", ZERO);

        nxt(); idle(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        step("fwdA_M", 12'b0000_000_10_00_0);
        nxt(); RegWriteM = 0;
        step("fwdA_W", 12'b0000_000_01_00_0);
        nxt(); idle(); RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1;
        step("fwd_x0", ZERO);
        nxt(); idle(); RdM = 9; RegWriteM = 1; RdW = 9; RegWriteW = 1; Rs2E = 9;
        step("fwdB_M", 12'b0000_000_00_10_0);

        nxt(); idle(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        step("loaduse", LUSE);
        nxt(); RdE = 0; ResultSrcE = 2'b00;
        step("loaduse_done", ZERO);
        nxt(); idle(); ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        step("loaduse_x0", ZERO);

        nxt(); idle(); PCSrcE = 1;
        step("branch", BRANCH);
        nxt(); ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        step("branch_and_lu", LU_BR);

        nxt(); idle(); MemAccM = 1; dmem_ready = 1;
        step("mem_ready_now", ZERO);
        for (int i = 0; i < 4; i++) begin
            nxt(); idle(); MemAccM = 1; dmem_ready = 0;
            if (i == 2) begin
                ResultSrcE = 2'b01; RdE = 4; Rs1D = 4; PCSrcE = 1;
            end
            step(i == 2 ? "mem_wait_lu" : "mem_wait", FREEZE);
        end
        nxt(); idle(); MemAccM = 1; dmem_ready = 1;
        step("mem_release", ZERO);
        nxt(); idle();
        step("mem_back_run", ZERO);

        for (int i = 0; i < 2; i++) begin
            nxt(); idle(); MemAccM = 1; dmem_ready = 0;
            step("abort_wait", FREEZE);
        end
        nxt(); rst_n = 1'b0;
        step("abort_reset", ZERO);
        nxt(); idle(); rst_n = 1'b1;
        step("abort_scrub", SCRUB);
        nxt();
        step("abort_idle", ZERO);

        for (int i = 0; i < TO + 1; i++) begin
            nxt(); idle(); MemAccM = 1; dmem_ready = 0;
            step("timeout_wait", FREEZE);
        end
        nxt();
        step("timeout_err", FRZERR);
        nxt(); idle(); dmem_ready = 1;
        step("err_sticky", FRZERR);
        nxt(); PCSrcE = 1;
        step("err_ignores_br", FRZERR);
        nxt(); rst_n = 1'b0;
        step("err_reset", ZERO);
        nxt(); idle(); rst_n = 1'b1;
        step("err_scrub", SCRUB);
        nxt();
        step("err_cleared", ZERO);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
